// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one UART byte transmitter.
// Define UART_ARB_LOCK_EN to enable multi-byte packet locking.
module uart_tx_arbiter #(
    parameter int MAX_LOCK    = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] TX_DATA,
    output logic       TX_EN,
    input  logic       TX_STATUS,
    output logic [1:0] grant,
    output logic       busy,
    output logic       lock,
    output logic       tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d;
    logic [1:0] grant_q, grant_d;
    logic       last_served_q, last_served_d;
    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic       tx_err_q, tx_err_d;
    logic       lock_held;
    logic       win0, win1;
    logic       accept;

    // Winner selection; only evaluated while idle with the transmitter free.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (state_q == IDLE && TX_STATUS) begin
            if (lock_held) begin
                win0 = grant_q[0] & req0_valid;
                win1 = grant_q[1] & req1_valid;
            end else if (req0_valid && req1_valid) begin
                win0 = last_served_q;
                win1 = ~last_served_q;
            end else begin
                win0 = req0_valid;
                win1 = req1_valid;
            end
        end
    end

    assign req0_ready = win0;
    assign req1_ready = win1;
    assign accept     = win0 | win1;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_en_d       = tx_en_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        timeout_cnt_d = timeout_cnt_q;
        tx_err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d     = win1 ? req1_data : req0_data;
                    grant_d       = {win1, win0};
                    last_served_d = win1;
                    tx_en_d       = 1'b1;
                    timeout_cnt_d = 8'd0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (!TX_STATUS) begin
                    tx_en_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (timeout_cnt_q >= TIMEOUT_LAST) begin
                    // Transmitter never acknowledged: drop the byte.
                    tx_err_d = 1'b1;
                    tx_en_d  = 1'b0;
                    state_d  = IDLE;
                end else if (timeout_cnt_q != 8'hFF) begin
                    timeout_cnt_d = timeout_cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (TX_STATUS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'd0;
            tx_en_q       <= 1'b0;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            timeout_cnt_q <= 8'd0;
            tx_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            timeout_cnt_q <= timeout_cnt_d;
            tx_err_q      <= tx_err_d;
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic       lock_q, lock_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [7:0] lock_cnt_inc;
    logic       acc_last;

    // Last byte or reaching the packet limit releases the lock; the owner
    // is already recorded as last served, so the other side wins the tie.
    always_comb begin
        lock_d       = lock_q;
        lock_cnt_d   = lock_cnt_q;
        acc_last     = win1 ? req1_last : req0_last;
        lock_cnt_inc = lock_cnt_q + 8'd1;
        if (accept) begin
            if (acc_last || lock_cnt_inc >= 8'(MAX_LOCK)) begin
                lock_d     = 1'b0;
                lock_cnt_d = 8'd0;
            end else begin
                lock_d     = 1'b1;
                lock_cnt_d = lock_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign lock_held = lock_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{req0_last, req1_last, 8'(MAX_LOCK)};
    assign lock_held  = 1'b0;
`endif

    assign TX_DATA = tx_data_q;
    assign TX_EN   = tx_en_q;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign lock    = lock_held;
    assign tx_err  = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a simple transmitter model
// that drops TX_STATUS one cycle after TX_EN and holds it low for 3 cycles.
module tb_uart_tx_arbiter;

    localparam int FRAME_LEN = 3;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic [1:0] grant;
    logic       busy, lock, tx_err;

    logic       model_busy;
    int         frame_cnt;
    logic       model_mute;
    logic       force_busy;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] txlog[$];
    logic       hs0, hs1;

    int   n_checks, n_pass;
    int   cyc, rdy0_cnt, rdy1_cnt, en_cnt, err_cnt, err_c, rdy_bad;
    int   status_rise_c, busy_fall_c;
    logic prev_en, prev_status, prev_busy, err_en, err_busy, lock_seen;

    uart_tx_arbiter #(.MAX_LOCK(16), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .TX_DATA    (tx_data),
        .TX_EN      (tx_en),
        .TX_STATUS  (tx_status),
        .grant      (grant),
        .busy       (busy),
        .lock       (lock),
        .tx_err     (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_busy <= 1'b0;
            frame_cnt  <= 0;
        end else if (model_busy) begin
            if (frame_cnt == 0) model_busy <= 1'b0;
            else frame_cnt <= frame_cnt - 1;
        end else if (tx_en && !model_mute) begin
            model_busy <= 1'b1;
            frame_cnt  <= FRAME_LEN - 1;
        end
    end

    assign tx_status = !(model_busy || force_busy);

    task automatic clear_stats();
        cyc = 0; rdy0_cnt = 0; rdy1_cnt = 0; en_cnt = 0; err_cnt = 0;
        err_c = -1; rdy_bad = 0; status_rise_c = -1; busy_fall_c = -1;
        prev_en = 1'b0; prev_status = 1'b1; prev_busy = 1'b0;
        err_en = 1'b1; err_busy = 1'b1; lock_seen = 1'b0;
        txlog.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        model_mute = 1'b0; force_busy = 1'b0;
        hs0 = 1'b0; hs1 = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
    endtask

    // Drives the requester queues cycle by cycle and records observations.
    task automatic drive(input int n);
        logic [8:0] e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (hs0 && q0.size() > 0) q0.delete(0);
            if (hs1 && q1.size() > 0) q1.delete(0);
            req0_valid = (q0.size() > 0);
            e = req0_valid ? q0[0] : 9'h000;
            req0_data = e[7:0]; req0_last = e[8];
            req1_valid = (q1.size() > 0);
            e = req1_valid ? q1[0] : 9'h000;
            req1_data = e[7:0]; req1_last = e[8];
            #1;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0) rdy0_cnt++;
            if (hs1) rdy1_cnt++;
            if ((req0_ready || req1_ready) && !tx_status) rdy_bad++;
            if (tx_en) en_cnt++;
            if (tx_en && !prev_en) txlog.push_back({grant, tx_data});
            if (tx_status && !prev_status && status_rise_c < 0) status_rise_c = cyc;
            if (!busy && prev_busy && busy_fall_c < 0) busy_fall_c = cyc;
            if (tx_err) begin
                err_cnt++; err_c = cyc; err_en = tx_en; err_busy = busy;
            end
            if (lock) lock_seen = 1'b1;
            prev_en = tx_en; prev_status = tx_status; prev_busy = busy;
            cyc++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); else n_pass++;
        n_checks++; if (tx_en !== 1'b0) $display("[TB] FAIL reset_tx_en got %b want 0", tx_en); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("[TB] FAIL reset_grant got %b want 00", grant); else n_pass++;
        n_checks++; if ({busy, lock, tx_err} !== 3'b000) $display("[TB] FAIL reset_flags got %b want 000", {busy, lock, tx_err}); else n_pass++;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("[TB] FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); else n_pass++;
    endtask

    task automatic test_single();
        logic [9:0] got;
        apply_reset();
        q0.push_back({1'b1, 8'h55});
        drive(12);
        got = (txlog.size() > 0) ? txlog[0] : 10'h3FF;
        n_checks++; if (rdy0_cnt !== 1) $display("[TB] FAIL single_ready_pulses got %0d want 1", rdy0_cnt); else n_pass++;
        n_checks++; if (got !== {2'b01, 8'h55}) $display("[TB] FAIL single_grant_data got %h want 155", got); else n_pass++;
        n_checks++; if (en_cnt !== 2) $display("[TB] FAIL single_tx_en_cycles got %0d want 2", en_cnt); else n_pass++;
        n_checks++; if (status_rise_c !== 5) $display("[TB] FAIL single_status_rise got %0d want 5", status_rise_c); else n_pass++;
        n_checks++; if (busy_fall_c !== 6) $display("[TB] FAIL single_busy_fall got %0d want 6", busy_fall_c); else n_pass++;
        n_checks++; if (grant !== 2'b01) $display("[TB] FAIL single_grant_hold got %b want 01", grant); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [9:0] exp_log[4];
        logic [9:0] got;
        apply_reset();
        q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h21});
        exp_log[0] = {2'b01, 8'h10}; exp_log[1] = {2'b10, 8'h20};
        exp_log[2] = {2'b01, 8'h11}; exp_log[3] = {2'b10, 8'h21};
        drive(30);
        n_checks++; if (txlog.size() !== 4) $display("[TB] FAIL alt_count got %0d want 4", txlog.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (txlog.size() > i) ? txlog[i] : 10'h3FF;
            n_checks++; if (got !== exp_log[i]) $display("[TB] FAIL alt_entry%0d got %h want %h", i, got, exp_log[i]); else n_pass++;
        end
    endtask

    task automatic test_status_hold();
        logic [9:0] got;
        apply_reset();
        force_busy = 1'b1;
        q1.push_back({1'b1, 8'h77});
        drive(10);
        n_checks++; if (rdy1_cnt !== 0) $display("[TB] FAIL hold_no_ready got %0d want 0", rdy1_cnt); else n_pass++;
        n_checks++; if (txlog.size() !== 0) $display("[TB] FAIL hold_no_issue got %0d want 0", txlog.size()); else n_pass++;
        force_busy = 1'b0;
        drive(10);
        got = (txlog.size() > 0) ? txlog[0] : 10'h3FF;
        n_checks++; if (rdy1_cnt !== 1) $display("[TB] FAIL hold_release_ready got %0d want 1", rdy1_cnt); else n_pass++;
        n_checks++; if (got !== {2'b10, 8'h77}) $display("[TB] FAIL hold_release_data got %h want 277", got); else n_pass++;
        n_checks++; if (rdy_bad !== 0) $display("[TB] FAIL hold_ready_while_busy got %0d want 0", rdy_bad); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        model_mute = 1'b1;
        q0.push_back({1'b1, 8'h3C});
        drive(14);
        n_checks++; if (err_cnt !== 1) $display("[TB] FAIL timeout_err_pulses got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (err_c !== 9) $display("[TB] FAIL timeout_err_cycle got %0d want 9", err_c); else n_pass++;
        n_checks++; if (en_cnt !== 8) $display("[TB] FAIL timeout_tx_en_cycles got %0d want 8", en_cnt); else n_pass++;
        n_checks++; if ({err_en, err_busy} !== 2'b00) $display("[TB] FAIL timeout_idle_at_err got %b want 00", {err_en, err_busy}); else n_pass++;
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        logic [9:0] exp_log[4];
        logic [9:0] got;
        apply_reset();
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
        q1.push_back({1'b1, 8'h81});
        exp_log[0] = {2'b01, 8'h01}; exp_log[1] = {2'b01, 8'h02};
        exp_log[2] = {2'b01, 8'h03}; exp_log[3] = {2'b10, 8'h81};
        drive(30);
        n_checks++; if (lock_seen !== 1'b1) $display("[TB] FAIL lock_asserted got %b want 1", lock_seen); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (txlog.size() > i) ? txlog[i] : 10'h3FF;
            n_checks++; if (got !== exp_log[i]) $display("[TB] FAIL lock_entry%0d got %h want %h", i, got, exp_log[i]); else n_pass++;
        end
        n_checks++; if (lock !== 1'b0) $display("[TB] FAIL lock_released got %b want 0", lock); else n_pass++;

        apply_reset();
        for (int i = 0; i < 20; i++) q0.push_back({(i == 19), 8'(8'h40 + i)});
        q1.push_back({1'b1, 8'h90});
        drive(140);
        n_checks++; if (txlog.size() !== 21) $display("[TB] FAIL maxlock_count got %0d want 21", txlog.size()); else n_pass++;
        got = (txlog.size() > 15) ? txlog[15] : 10'h3FF;
        n_checks++; if (got !== {2'b01, 8'h4F}) $display("[TB] FAIL maxlock_byte16 got %h want 14f", got); else n_pass++;
        got = (txlog.size() > 16) ? txlog[16] : 10'h3FF;
        n_checks++; if (got !== {2'b10, 8'h90}) $display("[TB] FAIL maxlock_req1_next got %h want 290", got); else n_pass++;
        got = (txlog.size() > 17) ? txlog[17] : 10'h3FF;
        n_checks++; if (got !== {2'b01, 8'h50}) $display("[TB] FAIL maxlock_byte17 got %h want 150", got); else n_pass++;
    endtask
`else
    task automatic test_lock();
        logic [9:0] exp_log[4];
        logic [9:0] got;
        apply_reset();
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02});
        q1.push_back({1'b0, 8'h81}); q1.push_back({1'b0, 8'h82});
        exp_log[0] = {2'b01, 8'h01}; exp_log[1] = {2'b10, 8'h81};
        exp_log[2] = {2'b01, 8'h02}; exp_log[3] = {2'b10, 8'h82};
        drive(30);
        n_checks++; if (lock_seen !== 1'b0) $display("[TB] FAIL nolock_lock_low got %b want 0", lock_seen); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (txlog.size() > i) ? txlog[i] : 10'h3FF;
            n_checks++; if (got !== exp_log[i]) $display("[TB] FAIL nolock_entry%0d got %h want %h", i, got, exp_log[i]); else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [9:0] got;
        apply_reset();
        q0.push_back({1'b1, 8'h5A});
        drive(4);
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL midreset_pre_busy got %b want 1", busy); else n_pass++;
        reset = 1'b0;
        q0.delete(); q1.delete();
        hs0 = 1'b0; hs1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++; if (tx_data !== 8'h00) $display("[TB] FAIL midreset_tx_data got %h want 00", tx_data); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("[TB] FAIL midreset_grant got %b want 00", grant); else n_pass++;
        n_checks++; if ({tx_en, busy, lock, tx_err} !== 4'b0000) $display("[TB] FAIL midreset_flags got %b want 0000", {tx_en, busy, lock, tx_err}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b1, 8'h66});
        drive(16);
        got = (txlog.size() > 0) ? txlog[0] : 10'h3FF;
        n_checks++; if (got !== {2'b01, 8'h12}) $display("[TB] FAIL midreset_first got %h want 112", got); else n_pass++;
        got = (txlog.size() > 1) ? txlog[1] : 10'h3FF;
        n_checks++; if (got !== {2'b10, 8'h66}) $display("[TB] FAIL midreset_second got %h want 266", got); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        $display("[TB] starting uart_tx_arbiter bench");
        test_reset();
        test_single();
        test_alternate();
        test_status_hold();
        test_timeout();
        test_lock();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter between two requesters (CPU peripheral path and debug/trace path). It accepts bytes through valid/ready handshakes, drives the transmitter's `TX_DATA`/`TX_EN` inputs, and tracks its `TX_STATUS` busy/idle flag so that a byte is never issued while a frame is in flight. It optionally locks the transmitter to one requester for a multi-byte packet.

## Interface
- `MAX_LOCK`, default 16: maximum bytes in one locked packet before the lock is force-released (range 1..255).
- `ACK_TIMEOUT`, default 8: cycles allowed in ISSUE for `TX_STATUS` to fall before an error is flagged (range 2..255).
- `clk  in  1`  system clock.
- `reset  in  1`  asynchronous, active-low reset.
- `req0_valid  in  1`  requester 0 has a byte.
- `req0_data  in  8`  requester 0 byte.
- `req0_last  in  1`  byte is the last byte of the packet (used only with the lock feature).
- `req0_ready  out  1`  combinational; the byte transfers on a clock edge where valid&ready.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0.
- `TX_DATA  out  8`  registered byte to the transmitter.
- `TX_EN  out  1`  registered issue strobe to the transmitter.
- `TX_STATUS  in  1`  transmitter flag: 1 = idle, 0 = frame in progress.
- `grant  out  2`  one-hot owner of the current or last transfer; 00 when none.
- `busy  out  1`  high in every state except IDLE.
- `lock  out  1`  high while a packet lock is held.
- `tx_err  out  1`  one-cycle pulse on an acknowledge timeout.

## Operation
- Reset values: `TX_DATA`=0, `TX_EN`=0, `grant`=00, `busy`=0, `lock`=0, `tx_err`=0, round-robin pointer `last_served`=1 (requester 0 wins the first tie), lock byte counter=0, state=IDLE.
- States:
  - IDLE: a winner is selected only when `TX_STATUS`=1. Winner rules:
    - only one valid: that requester wins.
    - both valid: the requester other than `last_served` wins.
    - lock held: only the lock owner can win.
  - IDLE, continued: `reqN_ready`=1 for the winner only. On the transfer edge:
    - latch the byte into `TX_DATA`.
    - set `grant`.
    - update `last_served`.
    - go to ISSUE.
  - ISSUE: `TX_EN`=1. Exit on `TX_STATUS`=0, clearing `TX_EN` and going to WAIT_DONE. If the timeout counter reaches `ACK_TIMEOUT` first: pulse `tx_err`, clear `TX_EN`, return to IDLE; the byte is dropped.
  - WAIT_DONE: wait for `TX_STATUS`=1, then go to IDLE. A new byte may be accepted in that same IDLE cycle.
- `reqN_ready` is 0 in every state except IDLE.
- A transfer never occurs while `TX_STATUS`=0, including in IDLE.
- The timeout counter is 8-bit, cleared on entry to ISSUE, and saturates.
- Reset asserted mid-frame forces all outputs to their reset values immediately. The transmitter is assumed to be reset by the same `reset`.

## Timing
- Latency: byte accepted at edge E; `TX_EN`=1 during cycle E..E+1. With a transmitter that responds in one cycle, `TX_STATUS` falls after edge E+1, `TX_EN` clears at edge E+2, and `TX_EN` is high for exactly 2 cycles.
- Back-to-back: next acceptance happens in the first cycle `TX_STATUS`=1 after WAIT_DONE, which is zero dead cycles in IDLE.
- `tx_err` is asserted for one cycle, coincident with the return to IDLE.
- Arbitration is fair: with both requesters continuously valid and no lock, grants alternate 0,1,0,1...

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - A transfer with `last`=0 sets `lock` and binds the owner; the other requester is held off even if valid.
  - The lock counter increments per accepted byte.
  - `lock` clears when the owner's byte with `last`=1 is accepted, or when the counter reaches `MAX_LOCK`. On a forced release, `last_served`=owner, so the other requester wins a tie.
- `UART_ARB_LOCK_EN` undefined: `reqN_last` is ignored, `lock` is tied to 0, arbitration happens per byte, and the lock counter is not built.

## Test plan
- Reset then `req0_valid` with 0x55, transmitter model responding in 1 cycle:
  - `req0_ready` pulses once.
  - `TX_DATA`=0x55 and `TX_EN` high for 2 cycles.
  - `grant`=01.
  - `busy` falls when `TX_STATUS` returns to 1.
- Both requesters continuously valid (req0 bytes 0x10.., req1 bytes 0x20..), no lock: transmitted order is 0x10,0x20,0x11,0x21; `grant` alternates 01,10.
- `TX_STATUS` held 0 externally while req1 is valid: `req1_ready` stays 0 and no transfer occurs until `TX_STATUS`=1.
- Transmitter model never drops `TX_STATUS`: after `ACK_TIMEOUT`=8 cycles in ISSUE, `tx_err` pulses once, `TX_EN`=0, and state returns to IDLE.
- With `UART_ARB_LOCK_EN`: req0 sends 3 bytes (last on the 3rd) while req1 is valid; req1 gets its first grant only after req0's 3rd byte. Separately, a 20-byte req0 packet with `MAX_LOCK`=16 releases after byte 16, and req1 is served next.
- Assert reset during WAIT_DONE: all outputs return to reset values within the same cycle, and the next request is granted normally.
